somador_dr_seq: RTL and testbench
=================================

SOMADOR_DR_SEQ -- requirements
Module: somador_dr_seq

Interface
REQ-001 Parameter N, default 8: operand width in logical bits; N >= 1.
REQ-002 Parameter K, default 2: logical bits added per clock; 1 <= K <= N; N SHALL be a multiple of K.
REQ-003 Dual-rail code per bit i, pair {X[2i+1],X[2i]}: 01 = logic 0, 10 = logic 1, 00 = NULL, 11 = illegal.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operands A, B, Cin present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 A  input  2N  operand A, dual-rail.
REQ-009 B  input  2N  operand B, dual-rail.
REQ-010 Cin  input  2  carry-in, dual-rail.
REQ-011 S  output  2N  sum, dual-rail.
REQ-012 Cout  output  2  carry-out, dual-rail.
REQ-013 out_valid  output  1  S, Cout, erro are valid.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 erro  output  1  accepted operand set contained a NULL or illegal pair.

Function
REQ-016 States: IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 Acceptance: in IDLE, in_valid=1 at a rising edge captures A, B, Cin into internal registers; inputs are ignored at all other times.
REQ-018 Acceptance with any pair of A, B or Cin equal to 00 or 11: next state DONE, erro=1, S and Cout held at NULL (all zeros).
REQ-019 Acceptance with all pairs legal: next state BUSY, chunk index 0, carry register loaded from Cin, erro=0.
REQ-020 BUSY: each edge adds logical bits [jK+K-1 : jK] of A and B plus the carry register, writes the K dual-rail sum pairs into the result register, updates carry, increments j.
REQ-021 After chunk N/K-1 the edge moves to DONE with Cout = final carry, dual-rail; out_valid rises exactly N/K edges after the acceptance edge.
REQ-022 Result SHALL equal (A + B + Cin) mod 2^N with Cout = bit N of the sum, for all legal inputs.
REQ-023 DONE: S, Cout, erro held stable until an edge with out_ready=1; that edge returns to IDLE.
REQ-024 Return-to-zero: whenever out_valid=0, S=0 and Cout=0 (NULL wavefront) and erro=0.
REQ-025 out_ready while not in DONE has no effect.
REQ-026 Acceptance and release cannot coincide (in_ready and out_valid mutually exclusive); back-to-back operations need at least one IDLE cycle.
REQ-027 Every output pair SHALL be 01, 10 or 00; never 11.
REQ-028 N/K = 1: BUSY lasts one edge; out_valid rises one edge after acceptance.

Reset
REQ-029 rst_n=0 immediately forces IDLE, clears operand, carry, result registers and chunk index; outputs: in_ready=1, out_valid=0, erro=0, S=0, Cout=0.
REQ-030 Reset asserted in BUSY or DONE aborts the operation; no result is ever presented for it.
REQ-031 First acceptance possible on the first rising edge with rst_n=1 and in_valid=1.

Verification (N=8, K=2)
REQ-032 A=0x5A, B=0x3C, Cin=0, all encoded legal -> out_valid 4 edges after accept, S decodes 0x96, Cout decodes 0, erro=0.
REQ-033 A=0xFF, B=0x01, Cin=0 -> S decodes 0x00, Cout decodes 1; and A=0xFF, B=0x00, Cin=1 -> S 0x00, Cout 1.
REQ-034 A bit 3 pair = 11 (rest legal) -> out_valid 1 edge after accept, erro=1, S=0, Cout=0; Cin pair = 00 gives the same response.
REQ-035 Legal result with out_ready=0 for 5 cycles -> S/Cout/out_valid stable all 5 cycles; out_ready=1 -> next cycle out_valid=0, S=0, in_ready=1.
REQ-036 rst_n pulsed low during BUSY chunk 2 -> outputs NULL immediately, in_ready=1; new operation 0x01+0x01 then yields S 0x02, Cout 0.
REQ-037 Random legal operands, N=8 with K in {1,2,4,8}: result matches reference sum; latency equals N/K edges.

Source files
------------

// File: rtl/somador_dr_seq.sv
// somador_dr_seq: dual-rail sequential adder, K logical bits per clock, NULL (all-zero) outputs outside DONE
module somador_dr_seq #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] A,
    input  logic [2*N-1:0] B,
    input  logic [1:0]     Cin,
    output logic [2*N-1:0] S,
    output logic [1:0]     Cout,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           erro
);
    localparam int NC = N / K;
    localparam int JW = NC > 1 ? $clog2(NC) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [N-1:0]   a_r, b_r, a_d, b_d;
    logic [2*N-1:0] res, res_nx;
    logic [1:0]     cout_r;
    logic           carry, erro_r, legal, last, c_nx;
    logic [JW-1:0]  j;
    logic [K-1:0]   s_k;
    logic [2*K-1:0] s_enc;

    always_comb begin
        legal = Cin[1] ^ Cin[0];
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < N; i++) begin
            a_d[i] = A[2*i+1];
            b_d[i] = B[2*i+1];
            legal = legal & (A[2*i+1] ^ A[2*i]) & (B[2*i+1] ^ B[2*i]);
        end
    end

    // operands shift right each chunk so the active chunk is always the low K bits
    assign {c_nx, s_k} = {1'b0, a_r[K-1:0]} + {1'b0, b_r[K-1:0]} + {{K{1'b0}}, carry};

    always_comb begin
        s_enc = '0;
        for (int i = 0; i < K; i++) s_enc[2*i +: 2] = {s_k[i], ~s_k[i]};
    end

    // result fills from the top so chunk 0 ends up in the low pairs after N/K shifts
    if (K == N) begin : g_full
        assign res_nx = s_enc;
    end else begin : g_part
        assign res_nx = {s_enc, res[2*N-1:2*K]};
    end

    assign last = j == JW'(NC - 1);

    always_comb
        state_nx = (state == IDLE && in_valid) ? (legal ? BUSY : DONE) :
                   (state == BUSY && last)     ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            res    <= '0;
            cout_r <= '0;
            carry  <= 1'b0;
            erro_r <= 1'b0;
            j      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_r    <= a_d;
                b_r    <= b_d;
                carry  <= Cin[1];
                res    <= '0;
                cout_r <= '0;
                erro_r <= ~legal;
                j      <= '0;
            end else if (state == BUSY) begin
                a_r   <= a_r >> K;
                b_r   <= b_r >> K;
                carry <= c_nx;
                res   <= res_nx;
                j     <= j + 1'b1;
                if (last) cout_r <= {c_nx, ~c_nx};
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign S         = out_valid ? res : '0;
    assign Cout      = out_valid ? cout_r : 2'b00;
    assign erro      = out_valid & erro_r;
endmodule

// File: tb/tb_somador_dr_seq.sv
// tb_somador_dr_seq: scoreboard bench running directed and random operations on K = 2, 1, 4, 8 instances
module tb_somador_dr_seq;
    localparam int N = 8;
    localparam int NR = 40;

    logic clk = 1'b0;
    int compared = 0;
    int mismatched = 0;
    int ndone = 0;

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] enc(input logic [N-1:0] v);
        logic [2*N-1:0] r;
        for (int i = 0; i < N; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [N-1:0] dec(input logic [2*N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    function automatic logic legal_dr(input logic [2*N-1:0] v);
        for (int i = 0; i < N; i++) if (v[2*i+1] == v[2*i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL K=%0d %s: got %0h expected %0h", k, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : kt
        localparam int K = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8;
        localparam int NC = N / K;
        typedef struct {
            logic [2*N-1:0] s;
            logic [1:0]     c;
            logic           e;
            int             due;
        } exp_t;

        logic rst_n = 1'b1;
        logic in_valid = 1'b0;
        logic out_ready = 1'b0;
        logic in_ready, out_valid, erro;
        logic [2*N-1:0] a = '0;
        logic [2*N-1:0] b = '0;
        logic [2*N-1:0] s;
        logic [1:0] cin = 2'b00;
        logic [1:0] cout;
        exp_t q[$];
        int cyc = 0;
        int ormode = 1;
        logic seen = 1'b0;
        logic [2*N-1:0] hs;
        logic [1:0] hc;

        somador_dr_seq #(.N(N), .K(K)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
            .out_valid(out_valid), .out_ready(out_ready), .erro(erro)
        );

        always @(posedge clk) cyc <= cyc + 1;

        always @(negedge clk) out_ready = ormode == 0 ? 1'($urandom_range(0, 1)) : ormode == 2;

        always @(negedge clk) begin
            exp_t x;
            if (!out_valid) begin
                seen = 1'b0;
                chk("null S", K, 32'(s), 0);
                chk("null Cout", K, 32'(cout), 0);
                chk("null erro", K, 32'(erro), 0);
            end else if (!seen) begin
                seen = 1'b1;
                hs = s;
                hc = cout;
                chk("in_ready while out_valid", K, 32'(in_ready), 0);
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL K=%0d unexpected result: got S %0h with empty scoreboard", K, s);
                end else begin
                    x = q.pop_front();
                    chk("S", K, 32'(s), 32'(x.s));
                    chk("Cout", K, 32'(cout), 32'(x.c));
                    chk("erro", K, 32'(erro), 32'(x.e));
                    chk("latency cycle", K, cyc, x.due);
                end
            end else begin
                chk("S stable", K, 32'(s), 32'(hs));
                chk("Cout stable", K, 32'(cout), 32'(hc));
            end
        end

        task automatic wait_idle();
            int t;
            t = 0;
            while (!in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                compared++;
                mismatched++;
                $display("FAIL K=%0d in_ready timeout: got 0 expected 1", K);
            end
        endtask

        task automatic issue(input logic [2*N-1:0] ea, input logic [2*N-1:0] eb, input logic [1:0] ec);
            exp_t x;
            int sum;
            wait_idle();
            if (legal_dr(ea) && legal_dr(eb) && ec[1] != ec[0]) begin
                sum = int'(dec(ea)) + int'(dec(eb)) + int'(ec[1]);
                x.s = enc(sum[N-1:0]);
                x.c = sum[N] ? 2'b10 : 2'b01;
                x.e = 1'b0;
                x.due = cyc + NC + 1;
            end else begin
                x.s = '0;
                x.c = 2'b00;
                x.e = 1'b1;
                x.due = cyc + 1;
            end
            q.push_back(x);
            a = ea;
            b = eb;
            cin = ec;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            a = (2*N)'($urandom);
            b = (2*N)'($urandom);
            cin = 2'($urandom);
        endtask

        initial begin
            logic [2*N-1:0] ea, eb;
            logic [1:0] ec, bad;
            int p, t;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            chk("reset in_ready", K, 32'(in_ready), 1);
            chk("reset out_valid", K, 32'(out_valid), 0);
            chk("reset S", K, 32'(s), 0);
            chk("reset Cout", K, 32'(cout), 0);
            chk("reset erro", K, 32'(erro), 0);
            rst_n = 1'b1;
            ormode = 0;
            issue(enc(8'h5A), enc(8'h3C), 2'b01);
            issue(enc(8'hFF), enc(8'h01), 2'b01);
            issue(enc(8'hFF), enc(8'h00), 2'b10);
            issue(enc(8'h5A) | 16'h00C0, enc(8'h3C), 2'b01);
            issue(enc(8'h5A), enc(8'h3C), 2'b00);
            wait_idle();
            ormode = 1;
            issue(enc(8'hA7), enc(8'h6B), 2'b10);
            t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("held out_valid", K, 32'(out_valid), 1);
            end
            #1 ormode = 2;
            @(negedge clk);
            @(negedge clk);
            chk("release out_valid", K, 32'(out_valid), 0);
            chk("release in_ready", K, 32'(in_ready), 1);
            chk("release S", K, 32'(s), 0);
            ormode = 0;
            issue(enc(8'h12), enc(8'h34), 2'b01);
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk("abort in_ready", K, 32'(in_ready), 1);
            chk("abort out_valid", K, 32'(out_valid), 0);
            chk("abort S", K, 32'(s), 0);
            chk("abort Cout", K, 32'(cout), 0);
            q.delete();
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            issue(enc(8'h01), enc(8'h01), 2'b01);
            for (int n = 0; n < NR; n++) begin
                ea = enc(N'($urandom));
                eb = enc(N'($urandom));
                ec = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                if ($urandom_range(0, 7) == 0) begin
                    p = $urandom_range(0, 2 * N);
                    bad = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                    if (p < N) ea[2*p +: 2] = bad;
                    else if (p < 2 * N) eb[2*(p-N) +: 2] = bad;
                    else ec = bad;
                end
                issue(ea, eb, ec);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            t = 0;
            while (q.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL K=%0d drain: %0d results outstanding, expected 0", K, q.size());
            end
            ndone++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (ndone < 4 && t < 40000) begin
            @(posedge clk);
            t++;
        end
        if (ndone < 4) begin
            compared++;
            mismatched++;
            $display("FAIL watchdog: %0d runs finished, expected 4", ndone);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
